blackjack_round_ctrl: RTL
=========================

# blackjack_round_ctrl

Parametrised single-player blackjack round controller with a bankroll. It takes a bet and deals cards from an external card source over a request/valid handshake. It tracks player and dealer hands with soft-ace scoring, runs the dealer draw rule, applies an optional N-card-charlie rule, and settles the bet back into the bankroll. The block sits between the pushbutton/switch inputs and the seven-segment display logic.

## Interface
- `MAX_CARDS`, 5: player hand limit, 2..8.
- `MONEY_W`, 10: width of `bank` and `bet`.
- `START_BANK`, 100: bankroll after reset.
- `DEALER_STAND`, 17: dealer stands at soft or hard total ≥ this value.
- `BJ_3_2`, 1: 1 = natural pays 3:2 (floor); 0 = natural pays 1:1.
- `CHARLIE`, 1: 1 = player holding `MAX_CARDS` cards without busting wins outright.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a round from BET, or leaves RESULT.
- `hit`, `stand` in 1: one-cycle pulses, sampled only in PLAYER.
- `increment_1`, `increment_5`, `increment_10`, `increment_25` in 1: one-cycle bet pulses, sampled only in BET.
- `card_req` out 1: card wanted.
- `card_valid` in 1: card present.
- `card_rank` in 4: 1=A, 2..10, 11..13=J/Q/K.
- `bank` out MONEY_W: current bankroll.
- `bet` out MONEY_W: current bet.
- `player_total`, `dealer_total` out 5: best total (soft if ≤21).
- `player_cards` out 4: player card count.
- `win`, `tie`, `lose`, `natural` out 1: result flags, valid in RESULT only.
- `card_err` out 1: one-cycle pulse on an invalid rank.

## Operation
- FSM states: BET, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, PLAYER, P_DRAW, DEALER, D_DRAW, SETTLE, RESULT.
- Reset: state BET, `bank`=START_BANK, `bet`=0. All totals, counts, flags, `card_req` and `card_err` are 0.
- BET:
  - The sum of increment pulses asserted in the same cycle is added to `bet`.
  - `bet` saturates at `bank`.
  - `start` with `bet`=0 is ignored.
  - Otherwise go to DEAL_P1 and set `bank` ← `bank`−`bet`.
- Draw states (DEAL_*, P_DRAW, D_DRAW): `card_req`=1.
  - A card is accepted in a cycle with `card_valid`=1 and rank 1..13.
  - Rank 0 or 14..15: pulse `card_err`, keep `card_req` high, stay in the state.
- Card points: A=1 (hard), 2..10 face value, 11..13=10.
- Soft total = hard total + 10 when the hand holds an ace and hard total + 10 ≤ 21.
- Deal order is P1, D1, P2, D2, then CHECK.
- CHECK (naturals):
  - Both hands 21 → tie.
  - Player 21 only → win with `natural`=1.
  - Dealer 21 only → lose.
  - Otherwise go to PLAYER.
- PLAYER:
  - `stand` has priority over a simultaneous `hit`; `stand` → DEALER.
  - `hit` → P_DRAW.
  - P_DRAW returns to PLAYER, or goes to SETTLE as lose if the total is >21.
  - If CHARLIE=1 and the count reaches MAX_CARDS at ≤21 → win (dealer does not draw).
  - If CHARLIE=0, `hit` at MAX_CARDS is ignored.
- DEALER: total ≥ DEALER_STAND → SETTLE; else D_DRAW, then back to DEALER.
- SETTLE:
  - Dealer >21 → win.
  - Player > dealer → win; equal → tie; less → lose.
- Payout on entry to RESULT, with `bank` saturating at all-ones:
  - Win: `bet`×2.
  - Natural: `bet`×2 + `bet`>>1 when BJ_3_2=1.
  - Tie: `bet`.
  - Lose: 0.
- RESULT: flags held. `start` → BET with `bet`=0 and hands cleared.

## Timing
- Every state transition and register update occurs on the `clk` edge following the qualifying input.
- A card accepted in cycle n is reflected in the totals in cycle n+1.
- A `card_valid` with no request (`card_req`=0) is ignored.
- Minimum round with no hits: 4 deal cycles + CHECK + PLAYER + DEALER + SETTLE → RESULT.
- `rst` mid-round: state returns to BET and `bank` to START_BANK. The in-flight bet is lost.
- Exactly one of `win`/`tie`/`lose` is high in RESULT. All three are 0 in every other state.

## Structure
- `blackjack_pkg`:
  - state enum;
  - result enum;
  - rank→points function;
  - the constant 21.
- Sub-module `bj_hand_acc`, instantiated twice (player and dealer):
  - inputs `clear`, `add`, `rank`;
  - outputs hard total, soft/best total, count, `has_ace`, `natural`.

## Test plan
- Reset; pulse `increment_25` then `increment_10` → `bet`=35. Pulse `start` → `bank`=65.
- `bet`=10; cards A, 9, K, 7 → CHECK asserts `natural`. With BJ_3_2=1 → `bank` ends at 90+25=115.
- Cards 10, 6, 5, 10; stand → dealer draws 2 to reach 18. Player 15 loses → `bank`=90.
- Player hits to 5 cards 2, 3, 2, 4, 3 (total 14) with CHARLIE=1 → `win` with no dealer draw. Same hand with CHARLIE=0 → `hit` ignored.
- Rank 0 presented with `card_valid` → `card_err` pulses and `card_req` stays high; then rank 5 is accepted.
- `hit` and `stand` in the same cycle → DEALER. Assert `rst` during D_DRAW → BET with `bank`=100.

Source files
------------

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared states, results and card scoring for the round controller.
package blackjack_pkg;
    localparam logic [4:0] BJ = 5'd21;
    typedef enum logic [3:0] {
        BET, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK,
        PLAYER, P_DRAW, DEALER, D_DRAW, SETTLE, RESULT
    } state_t;
    typedef enum logic [2:0] {RES_NONE, RES_WIN, RES_NAT, RES_TIE, RES_LOSE} result_t;
    function automatic logic [3:0] rank_pts(input logic [3:0] rank);
        return rank > 4'd10 ? 4'd10 : rank;
    endfunction
    function automatic logic rank_ok(input logic [3:0] rank);
        return rank != 4'd0 && rank < 4'd14;
    endfunction
endpackage

// File: rtl/blackjack_round_ctrl_if.sv
// blackjack_round_ctrl_if: request/valid handshake to the external card source.
interface blackjack_round_ctrl_if;
    logic       card_req;
    logic       card_valid;
    logic [3:0] card_rank;
    modport master(output card_req, input card_valid, card_rank);
    modport slave(input card_req, output card_valid, card_rank);
endinterface

// File: rtl/bj_hand_acc.sv
// bj_hand_acc: accumulates one hand, reporting hard/best totals, card count and natural.
module bj_hand_acc
    import blackjack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] rank,
    output logic [4:0] hard,
    output logic [4:0] best,
    output logic [3:0] count,
    output logic       has_ace,
    output logic       natural
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hard    <= '0;
            count   <= '0;
            has_ace <= 1'b0;
        end else if (add) begin
            hard    <= hard + 5'(rank_pts(rank));
            count   <= count == 4'hf ? count : count + 4'd1;
            has_ace <= has_ace || rank == 4'd1;
        end
    end
    assign best    = has_ace && hard <= 5'd11 ? hard + 5'd10 : hard;
    assign natural = count == 4'd2 && best == BJ;
endmodule

// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: one-player blackjack round with betting, dealer rule, charlie and payout.
module blackjack_round_ctrl
    import blackjack_pkg::*;
#(
    parameter int MAX_CARDS    = 5,
    parameter int MONEY_W      = 10,
    parameter int START_BANK   = 100,
    parameter int DEALER_STAND = 17,
    parameter int BJ_3_2       = 1,
    parameter int CHARLIE      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hit,
    input  logic                  stand,
    input  logic                  increment_1,
    input  logic                  increment_5,
    input  logic                  increment_10,
    input  logic                  increment_25,
    blackjack_round_ctrl_if.master card,
    output logic [MONEY_W-1:0]    bank,
    output logic [MONEY_W-1:0]    bet,
    output logic [4:0]            player_total,
    output logic [4:0]            dealer_total,
    output logic [3:0]            player_cards,
    output logic                  win,
    output logic                  tie,
    output logic                  lose,
    output logic                  natural,
    output logic                  card_err
);
    localparam int W = MONEY_W;
    localparam logic [3:0] MAXC = 4'(MAX_CARDS);
    localparam logic [4:0] STAND = 5'(DEALER_STAND);
    state_t state, state_n;
    result_t res, res_n;
    logic draw, take, clear, p_add, d_add, p_ace, d_ace, p_nat, d_nat, d_stand, p_charlie;
    logic [4:0] p_hard, d_hard, np_hard, np_best;
    logic [3:0] unused_d_cards;
    logic [5:0] inc;
    logic [W:0] bet_sum;
    logic [W-1:0] bet_sat, bank_sat;
    logic [W+1:0] pay, bank_sum;

    assign draw = state inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, P_DRAW, D_DRAW};
    assign card.card_req = draw;
    assign take     = draw && card.card_valid && rank_ok(card.card_rank);
    assign card_err = draw && card.card_valid && !rank_ok(card.card_rank);
    assign p_add = take && state inside {DEAL_P1, DEAL_P2, P_DRAW};
    assign d_add = take && state inside {DEAL_D1, DEAL_D2, D_DRAW};
    assign clear = state == RESULT && start;

    bj_hand_acc u_player (.clk, .rst, .clear, .add(p_add), .rank(card.card_rank), .hard(p_hard),
        .best(player_total), .count(player_cards), .has_ace(p_ace), .natural(p_nat));
    bj_hand_acc u_dealer (.clk, .rst, .clear, .add(d_add), .rank(card.card_rank), .hard(d_hard),
        .best(dealer_total), .count(unused_d_cards), .has_ace(d_ace), .natural(d_nat));

    // The hit outcome is decided on the accepting edge, so score the incoming card ahead of the hand.
    assign np_hard   = p_hard + 5'(rank_pts(card.card_rank));
    assign np_best   = (p_ace || card.card_rank == 4'd1) && np_hard <= 5'd11 ? np_hard + 5'd10 : np_hard;
    assign p_charlie = CHARLIE != 0 && player_cards + 4'd1 == MAXC;
    assign d_stand   = d_hard >= STAND || (d_ace && d_hard <= 5'd11 && d_hard + 5'd10 >= STAND);

    assign inc = (increment_1 ? 6'd1 : 6'd0) + (increment_5 ? 6'd5 : 6'd0)
               + (increment_10 ? 6'd10 : 6'd0) + (increment_25 ? 6'd25 : 6'd0);
    assign bet_sum = (W+1)'(bet) + (W+1)'(inc);
    assign bet_sat = bet_sum > (W+1)'(bank) ? bank : bet_sum[W-1:0];
    assign pay = res_n == RES_WIN ? (W+2)'(bet) << 1
               : res_n == RES_NAT ? ((W+2)'(bet) << 1) + (BJ_3_2 != 0 ? (W+2)'(bet >> 1) : '0)
               : res_n == RES_TIE ? (W+2)'(bet) : '0;
    assign bank_sum = (W+2)'(bank) + pay;
    assign bank_sat = bank_sum > (W+2)'({W{1'b1}}) ? '1 : bank_sum[W-1:0];

    always_comb begin
        state_n = state;
        res_n   = res;
        case (state)
            BET:     state_n = start && bet != '0 ? DEAL_P1 : BET;
            DEAL_P1: state_n = take ? DEAL_D1 : state;
            DEAL_D1: state_n = take ? DEAL_P2 : state;
            DEAL_P2: state_n = take ? DEAL_D2 : state;
            DEAL_D2: state_n = take ? CHECK : state;
            CHECK: begin
                res_n   = p_nat && d_nat ? RES_TIE : p_nat ? RES_NAT : d_nat ? RES_LOSE : RES_NONE;
                state_n = p_nat || d_nat ? SETTLE : PLAYER;
            end
            PLAYER:  state_n = stand ? DEALER : hit && player_cards < MAXC ? P_DRAW : PLAYER;
            P_DRAW: if (take) begin
                res_n   = np_best > BJ ? RES_LOSE : p_charlie ? RES_WIN : RES_NONE;
                state_n = np_best > BJ || p_charlie ? SETTLE : PLAYER;
            end
            DEALER:  state_n = d_stand ? SETTLE : D_DRAW;
            D_DRAW:  state_n = take ? DEALER : D_DRAW;
            SETTLE: begin
                state_n = RESULT;
                if (res == RES_NONE)
                    res_n = d_hard > BJ || player_total > dealer_total ? RES_WIN
                          : player_total == dealer_total ? RES_TIE : RES_LOSE;
            end
            RESULT: begin
                state_n = start ? BET : RESULT;
                res_n   = start ? RES_NONE : res;
            end
            default: state_n = BET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BET;
            res   <= RES_NONE;
            bank  <= W'(START_BANK);
            bet   <= '0;
        end else begin
            state <= state_n;
            res   <= res_n;
            if (state == BET && state_n == DEAL_P1) bank <= bank - bet;
            else if (state == SETTLE) bank <= bank_sat;
            if (state == BET && state_n == BET) bet <= bet_sat;
            else if (clear) bet <= '0;
        end
    end

    assign win     = state == RESULT && (res == RES_WIN || res == RES_NAT);
    assign tie     = state == RESULT && res == RES_TIE;
    assign lose    = state == RESULT && res == RES_LOSE;
    assign natural = state == RESULT && res == RES_NAT;
endmodule
